// File: rtl/des_key_scheduler.sv
// Iterative DES/3DES round-key generator: one 48-bit subkey per cycle, first subkey the cycle after start.
// Backpressure: subkey and tags hold while sk_valid is high without sk_ready (unless BACKPRESSURE=0).
module des_key_scheduler #(
    parameter int NUM_KEYS     = 1,
    parameter int BACKPRESSURE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   decrypt,
    input  logic [64*NUM_KEYS-1:0] key_in,
    output logic                   busy,
    output logic                   sk_valid,
    input  logic                   sk_ready,
    output logic [47:0]            sk_data,
    output logic [3:0]             sk_round,
    output logic [1:0]             sk_key_idx,
    output logic                   sk_last,
    output logic                   done
);
    localparam int NPASS = (NUM_KEYS == 1) ? 1 : 3;

    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Bit r set where round r (0-based) uses a two-place rotation.
    localparam logic [15:0] SH2 = 16'h7EFC;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src    = 6'(64 - PC1[i]);
            dst    = 6'(55 - i);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src    = 6'(56 - PC2[i]);
            dst    = 6'(47 - i);
            r[dst] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic two, input logic right);
        if (right)
            return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    // Forward passes start at C1/D1; reverse passes start at C0/D0, which equals C16/D16.
    function automatic logic [55:0] load_cd(input logic [63:0] k, input logic rev);
        logic [55:0] p;
        p = pc1(k);
        if (rev)
            return p;
        return {rot28(p[55:28], 1'b0, 1'b0), rot28(p[27:0], 1'b0, 1'b0)};
    endfunction

    function automatic logic [1:0] pass_slot(input logic [1:0] p, input logic dec);
        if (NPASS == 1)
            return 2'd0;
        return dec ? 2'd2 - p : p;
    endfunction

    function automatic logic pass_rev(input logic [1:0] p, input logic dec);
        if (NPASS == 1)
            return dec;
        return dec ? (p != 2'd1) : (p == 2'd1);
    endfunction

    // Slots beyond NUM_KEYS alias key 0 (two-key EDE reuses k1 as k3).
    function automatic logic [63:0] slot_key(input logic [191:0] k, input logic [1:0] s);
        logic [1:0] eff;
        eff = (s < 2'(NUM_KEYS)) ? s : 2'd0;
        case (eff)
            2'd1:    return k[127:64];
            2'd2:    return k[191:128];
            default: return k[63:0];
        endcase
    endfunction

    state_t       state_q;
    logic [191:0] keys_q;
    logic         decrypt_q;
    logic [55:0]  cd_q;
    logic [1:0]   pass_q;
    logic [1:0]   slot_q;
    logic         rev_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         last_q;
    logic         busy_q;
    logic         done_q;

    logic [191:0] key_in_pad;
    logic         xfer;
    logic         pass_end;
    logic         final_pass;
    logic [1:0]   start_slot_d;
    logic         start_rev_d;
    logic [55:0]  start_cd_d;
    logic [1:0]   next_pass_d;
    logic [1:0]   next_slot_d;
    logic         next_rev_d;
    logic [55:0]  next_cd_d;
    logic [3:0]   step_rnd_d;
    logic         step_two_d;
    logic [55:0]  step_cd_d;
    logic         step_last_d;

    assign key_in_pad   = 192'(key_in);
    assign xfer         = valid_q & (sk_ready | (BACKPRESSURE == 0));
    assign pass_end     = (round_q == (rev_q ? 4'd0 : 4'd15));
    assign final_pass   = (pass_q == 2'(NPASS - 1));

    assign start_slot_d = pass_slot(2'd0, decrypt);
    assign start_rev_d  = pass_rev(2'd0, decrypt);
    assign start_cd_d   = load_cd(slot_key(key_in_pad, start_slot_d), start_rev_d);

    assign next_pass_d  = pass_q + 2'd1;
    assign next_slot_d  = pass_slot(next_pass_d, decrypt_q);
    assign next_rev_d   = pass_rev(next_pass_d, decrypt_q);
    assign next_cd_d    = load_cd(slot_key(keys_q, next_slot_d), next_rev_d);

    // Going backwards undoes the shift of the round being left; going forwards applies the next one.
    assign step_rnd_d   = rev_q ? round_q - 4'd1 : round_q + 4'd1;
    assign step_two_d   = rev_q ? SH2[round_q] : SH2[step_rnd_d];
    assign step_cd_d    = {rot28(cd_q[55:28], step_two_d, rev_q), rot28(cd_q[27:0], step_two_d, rev_q)};
    assign step_last_d  = final_pass && (step_rnd_d == (rev_q ? 4'd0 : 4'd15));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            keys_q    <= '0;
            decrypt_q <= 1'b0;
            cd_q      <= '0;
            pass_q    <= '0;
            slot_q    <= '0;
            rev_q     <= 1'b0;
            round_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (xfer) begin
                        if (pass_end && final_pass) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0 | 1'b1;
                        end else if (pass_end) begin
                            pass_q  <= next_pass_d;
                            slot_q  <= next_slot_d;
                            rev_q   <= next_rev_d;
                            round_q <= next_rev_d ? 4'd15 : 4'd0;
                            cd_q    <= next_cd_d;
                            last_q  <= 1'b0;
                        end else begin
                            round_q <= step_rnd_d;
                            cd_q    <= step_cd_d;
                            last_q  <= step_last_d;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        keys_q    <= key_in_pad;
                        decrypt_q <= decrypt;
                        pass_q    <= 2'd0;
                        slot_q    <= start_slot_d;
                        rev_q     <= start_rev_d;
                        round_q   <= start_rev_d ? 4'd15 : 4'd0;
                        cd_q      <= start_cd_d;
                        valid_q   <= 1'b1;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign sk_valid   = valid_q;
    assign sk_data    = pc2(cd_q);
    assign sk_round   = round_q;
    assign sk_key_idx = slot_q;
    assign sk_last    = last_q;
    assign done       = done_q;
endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: single-key instance with backpressure, three-key EDE instance without.
module tb_des_key_scheduler;
    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
    localparam logic [63:0] KP = 64'h123557789ABDDEF0;
    localparam logic [63:0] KZ = 64'h0101010101010101;

    typedef struct packed {
        logic [54:0] v;
        int          cyc;
    } exp_t;

    logic [47:0] K [16] = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic        rst1, start1, dec1, ready1;
    logic [63:0] key1;
    logic        busy1, sk_valid1, sk_last1, done1;
    logic [47:0] sk_data1;
    logic [3:0]  sk_round1;
    logic [1:0]  sk_key_idx1;

    logic         rst3, start3, dec3, ready3;
    logic [191:0] key3;
    logic         busy3, sk_valid3, sk_last3, done3;
    logic [47:0]  sk_data3;
    logic [3:0]   sk_round3;
    logic [1:0]   sk_key_idx3;

    des_key_scheduler #(.NUM_KEYS(1), .BACKPRESSURE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .decrypt(dec1), .key_in(key1),
        .busy(busy1), .sk_valid(sk_valid1), .sk_ready(ready1), .sk_data(sk_data1),
        .sk_round(sk_round1), .sk_key_idx(sk_key_idx1), .sk_last(sk_last1), .done(done1)
    );

    des_key_scheduler #(.NUM_KEYS(3), .BACKPRESSURE(0)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .decrypt(dec3), .key_in(key3),
        .busy(busy3), .sk_valid(sk_valid3), .sk_ready(ready3), .sk_data(sk_data3),
        .sk_round(sk_round3), .sk_key_idx(sk_key_idx3), .sk_last(sk_last3), .done(done3)
    );

    exp_t q1 [$];
    exp_t q3 [$];
    int   dq1 [$];
    int   dq3 [$];
    exp_t e1, e3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Monitors: pop on every handshake, check holds during stalls and done timing.
    always @(negedge clk) begin
        if (!rst1) begin
            if (sk_valid1 && ready1) begin
                if (q1.size() == 0) unexpected("dut1 subkey");
                else begin
                    e1 = q1.pop_front();
                    chk("dut1 subkey", 64'({sk_data1, sk_round1, sk_key_idx1, sk_last1}), 64'(e1.v));
                    chk("dut1 xfer cycle", 64'(cyc), 64'(e1.cyc));
                end
            end else if (sk_valid1 && q1.size() > 0) begin
                chk("dut1 hold", 64'({sk_data1, sk_round1, sk_key_idx1, sk_last1}), 64'(q1[0].v));
            end
            if (done1) begin
                if (dq1.size() == 0) unexpected("dut1 done");
                else chk("dut1 done cycle", 64'(cyc), 64'(dq1.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3) begin
            if (sk_valid3) begin
                if (q3.size() == 0) unexpected("dut3 subkey");
                else begin
                    e3 = q3.pop_front();
                    chk("dut3 subkey", 64'({sk_data3, sk_round3, sk_key_idx3, sk_last3}), 64'(e3.v));
                    chk("dut3 xfer cycle", 64'(cyc), 64'(e3.cyc));
                end
            end
            if (done3) begin
                if (dq3.size() == 0) unexpected("dut3 done");
                else chk("dut3 done cycle", 64'(cyc), 64'(dq3.pop_front()));
            end
        end
    end

    // Single-key run; returns in the DONE cycle so a caller may start again there.
    task automatic launch1(input logic [63:0] key, input logic dec, input int st_at,
                           input int st_len, input bit poke);
        int         t;
        exp_t       e;
        logic [3:0] r;
        t      = cyc;
        key1   = key;
        dec1   = dec;
        start1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r     = dec ? 4'(15 - i) : 4'(i);
            e.v   = {K[r], r, 2'd0, (i == 15)};
            e.cyc = t + 1 + i + ((i >= st_at) ? st_len : 0);
            q1.push_back(e);
        end
        dq1.push_back(t + 17 + st_len);
        for (int c = t + 1; c <= t + 16 + st_len; c++) begin
            @(posedge clk); #1;
            start1 = poke && (c == t + 8);
            if (start1) key1 = '0;
            ready1 = !(st_len > 0 && c >= t + 1 + st_at && c < t + 1 + st_at + st_len);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        ready1 = 1'b1;
    endtask

    task automatic launch3(input logic [191:0] keys, input logic dec, input logic [2:0] zero);
        int         t;
        exp_t       e;
        logic [1:0] s;
        logic       rv;
        logic [3:0] r;
        t      = cyc;
        key3   = keys;
        dec3   = dec;
        start3 = 1'b1;
        for (int p = 0; p < 3; p++) begin
            s  = dec ? 2'(2 - p) : 2'(p);
            rv = dec ? (p != 1) : (p == 1);
            for (int i = 0; i < 16; i++) begin
                r     = rv ? 4'(15 - i) : 4'(i);
                e.v   = {(zero[s] ? 48'h0 : K[r]), r, s, (p == 2 && i == 15)};
                e.cyc = t + 1 + 16 * p + i;
                q3.push_back(e);
            end
        end
        dq3.push_back(t + 49);
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (48) begin
            ready3 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ready3 = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q1.size() + q3.size() + dq1.size() + dq3.size()) > 0; i++)
            @(posedge clk);
        chk("pending expectations", 64'(q1.size() + q3.size() + dq1.size() + dq3.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic abort_run();
        int   t;
        exp_t e;
        t      = cyc;
        key1   = K0;
        dec1   = 1'b0;
        start1 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.v   = {K[i], 4'(i), 2'd0, 1'b0};
            e.cyc = t + 1 + i;
            q1.push_back(e);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("abort outputs", 64'({busy1, sk_valid1, sk_data1, sk_round1, sk_key_idx1, sk_last1, done1}), 64'd0);
        rst1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; start1 = 1'b0; dec1 = 1'b0; ready1 = 1'b1; key1 = '0;
        rst3 = 1'b1; start3 = 1'b0; dec3 = 1'b0; ready3 = 1'b1; key3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dut1", 64'({busy1, sk_valid1, sk_data1, sk_round1, sk_key_idx1, sk_last1, done1}), 64'd0);
        chk("reset dut3", 64'({busy3, sk_valid3, sk_data3, sk_round3, sk_key_idx3, sk_last3, done3}), 64'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        launch1(K0, 1'b0, 0, 0, 1'b0);
        drain();
        launch1(K0, 1'b1, 0, 0, 1'b0);
        drain();
        launch1(K0, 1'b0, 3, 3, 1'b0);
        drain();
        abort_run();
        drain();
        launch1(KP, 1'b0, 0, 0, 1'b0);
        drain();
        launch1(K0, 1'b0, 0, 0, 1'b1);
        launch1(K0, 1'b1, 0, 0, 1'b0);
        drain();

        launch3({K0, K0, K0}, 1'b0, 3'b000);
        drain();
        launch3({KP, KZ, K0}, 1'b1, 3'b010);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
